// File: rtl/multi_title_overlay_if.sv
// Pixel-stream and per-channel title bus between a video timing source and the title overlay.
// The overlay consumes the slave view; the pixel source and bitmap ROMs drive the master view.
interface multi_title_overlay_if #(
    parameter int unsigned NUM_TITLES = 4
);
    logic                        startOfFrame;
    logic [10:0]                 pixelX;
    logic [10:0]                 pixelY;
    logic [11*NUM_TITLES-1:0]    topLeftX;
    logic [11*NUM_TITLES-1:0]    topLeftY;
    logic [NUM_TITLES-1:0]       chanEn;
    logic [NUM_TITLES-1:0]       blinkEn;
    logic [NUM_TITLES-1:0]       flashEn;
    logic [NUM_TITLES-1:0]       bmDR;
    logic [8*NUM_TITLES-1:0]     bmRGB;
    logic [11*NUM_TITLES-1:0]    offsetX;
    logic [11*NUM_TITLES-1:0]    offsetY;
    logic [NUM_TITLES-1:0]       insideRect;
    logic                        blinkPhase;
    logic                        titlesDR;
    logic [7:0]                  titlesRGB;

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
               chanEn, blinkEn, flashEn, bmDR, bmRGB,
        input  offsetX, offsetY, insideRect, blinkPhase, titlesDR, titlesRGB
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
               chanEn, blinkEn, flashEn, bmDR, bmRGB,
        output offsetX, offsetY, insideRect, blinkPhase, titlesDR, titlesRGB
    );
endinterface

// File: rtl/multi_title_overlay.sv
// Multi-channel title overlay: per-channel rectangle hit test and bitmap offsets, then a
// priority merge of the bitmap pixels with per-channel blink/flash effects. Latency 2 cycles.
module multi_title_overlay #(
    parameter int unsigned NUM_TITLES = 4,
    parameter int unsigned TITLE_W    = 64,
    parameter int unsigned TITLE_H    = 16,
    parameter int unsigned BLINK_HALF = 30,
    parameter logic [7:0]  FLASH_RGB  = 8'hFF
) (
    input logic                   clk,
    input logic                   reset,
    multi_title_overlay_if.slave  bus
);
    localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    // 12-bit compare so a span reaching past 2047 is clipped instead of wrapping to column 0.
    function automatic logic inSpan(input logic [10:0] p, input logic [10:0] lo,
                                    input int unsigned len);
        logic [11:0] hi;
        hi = {1'b0, lo} + 12'(len) - 12'd1;
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} <= hi);
    endfunction

    logic [NUM_TITLES-1:0]    hit_p0;
    logic [11*NUM_TITLES-1:0] offX_p0;
    logic [11*NUM_TITLES-1:0] offY_p0;

    logic [NUM_TITLES-1:0]    insideRect_p1;
    logic [11*NUM_TITLES-1:0] offsetX_p1;
    logic [11*NUM_TITLES-1:0] offsetY_p1;
    logic                     vld_p1;

    logic                     winDR_p1;
    logic [7:0]               winRGB_p1;

    logic                     titlesDR_p2;
    logic [7:0]               titlesRGB_p2;

    logic [CNT_W-1:0]         blinkCnt;
    logic                     blinkPhase;

    // Stage p0 -> p1: rectangle hit test and bitmap offsets
    always_comb begin
        hit_p0  = '0;
        offX_p0 = '0;
        offY_p0 = '0;
        for (int i = 0; i < int'(NUM_TITLES); i++) begin
            hit_p0[i] = bus.chanEn[i]
                      && inSpan(bus.pixelX, bus.topLeftX[11*i +: 11], TITLE_W)
                      && inSpan(bus.pixelY, bus.topLeftY[11*i +: 11], TITLE_H);
            if (hit_p0[i]) begin
                offX_p0[11*i +: 11] = bus.pixelX - bus.topLeftX[11*i +: 11];
                offY_p0[11*i +: 11] = bus.pixelY - bus.topLeftY[11*i +: 11];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insideRect_p1 <= '0;
            offsetX_p1    <= '0;
            offsetY_p1    <= '0;
            vld_p1        <= 1'b0;
        end else begin
            insideRect_p1 <= hit_p0;
            offsetX_p1    <= offX_p0;
            offsetY_p1    <= offY_p0;
            vld_p1        <= 1'b1;
        end
    end

    // Stage p1 -> p2: priority merge; descending scan lets the lowest eligible index win
    always_comb begin
        winDR_p1  = 1'b0;
        winRGB_p1 = 8'h00;
        for (int i = int'(NUM_TITLES) - 1; i >= 0; i--) begin
            if (insideRect_p1[i] && bus.bmDR[i] && (!bus.blinkEn[i] || blinkPhase)) begin
                winDR_p1  = 1'b1;
                winRGB_p1 = (bus.flashEn[i] && !blinkPhase) ? FLASH_RGB : bus.bmRGB[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            titlesDR_p2  <= 1'b0;
            titlesRGB_p2 <= 8'h00;
        end else begin
            titlesDR_p2  <= vld_p1 && winDR_p1;
            titlesRGB_p2 <= vld_p1 ? winRGB_p1 : 8'h00;
        end
    end

    // Merge stage above reads the pre-toggle phase when startOfFrame lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
        end else if (bus.startOfFrame) begin
            if (blinkCnt == CNT_LAST) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + 1'b1;
            end
        end
    end

    assign bus.insideRect = insideRect_p1;
    assign bus.offsetX    = offsetX_p1;
    assign bus.offsetY    = offsetY_p1;
    assign bus.blinkPhase = blinkPhase;
    assign bus.titlesDR   = titlesDR_p2;
    assign bus.titlesRGB  = titlesRGB_p2;
endmodule
